// File: rtl/mem_fmt_pkg.sv
// Shared funct3 and access-size definitions for the load/store byte-lane formatter.
package mem_fmt_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Access size as carried in funct3[1:0]; 11 is not a legal store size.
  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } mem_size_t;

endpackage

// File: rtl/mem_lane_decode.sv
// Byte-enable mask and misalignment flag for an access of a given size at a byte offset.
module mem_lane_decode
  import mem_fmt_pkg::*;
(
  input  mem_size_t   i_size,
  input  logic [1:0]  i_addr,
  output logic [3:0]  o_mask,
  output logic        o_misaligned
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    o_mask       = 4'b0000;
    o_misaligned = 1'b0;
    unique case (i_size)
      SZ_B: o_mask = 4'b0001 << i_addr;
      SZ_H: begin
        o_mask       = i_addr[1] ? 4'b1100 : 4'b0011;
        o_misaligned = i_addr[0];
      end
      SZ_W: begin
        o_mask       = 4'b1111;
        o_misaligned = (i_addr != 2'b00);
      end
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_format.sv
// Combinational load extraction / store lane replication with registered misalignment status.
module load_store_format
  import mem_fmt_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 cpu_clock_i,
  input  logic                 cpu_reset_i,
  input  logic                 valid_i,
  input  logic                 is_store_i,
  input  logic [1:0]           addr_i,
  input  logic [2:0]           mem_ctrl_i,
  input  logic [31:0]          ld_raw_i,
  output logic [31:0]          ld_data_o,
  input  logic [31:0]          st_data_i,
  output logic [31:0]          st_data_o,
  output logic [3:0]           st_sel_o,
  output logic                 misalign_o,
  output logic                 err_sticky_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  mem_size_t   w_size;
  logic        w_dec_mis;
  logic        w_ld_mis;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        r_sticky;
  logic [ERR_CNT_W-1:0] r_count;

  assign w_size = mem_size_t'(mem_ctrl_i[1:0]);

  mem_lane_decode u_lane_decode (
    .i_size       (w_size),
    .i_addr       (addr_i),
    .o_mask       (st_sel_o),
    .o_misaligned (w_dec_mis)
  );

  // Loads treat size 11 as a plain word, so only the word-alignment rule applies there.
  assign w_ld_mis   = (w_size == SZ_ILL) ? (addr_i != 2'b00) : w_dec_mis;
  assign misalign_o = valid_i & (is_store_i ? w_dec_mis : w_ld_mis);

  always_comb begin
    w_byte = ld_raw_i[7:0];
    unique case (addr_i)
      2'd0: w_byte = ld_raw_i[7:0];
      2'd1: w_byte = ld_raw_i[15:8];
      2'd2: w_byte = ld_raw_i[23:16];
      2'd3: w_byte = ld_raw_i[31:24];
    endcase
  end

  assign w_half = addr_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];

  always_comb begin
    ld_data_o = ld_raw_i;
    case (mem_ctrl_i)
      F3_LB:   ld_data_o = {{24{w_byte[7]}}, w_byte};
      F3_LH:   ld_data_o = {{16{w_half[15]}}, w_half};
      F3_LBU:  ld_data_o = {24'h0, w_byte};
      F3_LHU:  ld_data_o = {16'h0, w_half};
      default: ld_data_o = ld_raw_i;
    endcase
  end

  always_comb begin
    st_data_o = st_data_i;
    unique case (w_size)
      SZ_B:    st_data_o = {4{st_data_i[7:0]}};
      SZ_H:    st_data_o = {2{st_data_i[15:0]}};
      default: st_data_o = st_data_i;
    endcase
  end

  always_ff @(posedge cpu_clock_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (cpu_reset_i) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else if (misalign_o) begin
      r_sticky <= 1'b1;
      if (r_count != '1)
        r_count <= r_count + 1'b1;
    end
  end

  assign err_sticky_o = r_sticky;
  assign err_count_o  = r_count;

endmodule

// File: tb/tb_load_store_format.sv
// Self-checking bench: directed test-plan steps followed by random operations against a reference model.
module tb_load_store_format;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, is_store;
  logic [1:0]  addr;
  logic [2:0]  ctrl;
  logic [31:0] ld_raw, st_in;

  logic [31:0] ld_data_a, st_data_a, ld_data_b, st_data_b;
  logic [3:0]  st_sel_a, st_sel_b;
  logic        mis_a, mis_b, sticky_a, sticky_b;
  logic [7:0]  count_a;
  logic [1:0]  count_b;

  int checks   = 0;
  int failures = 0;

  // Reference error state: total misaligned cycles since reset.
  int  ref_cnt    = 0;
  bit  ref_sticky = 1'b0;

  always #5 clk = ~clk;

  load_store_format #(.ERR_CNT_W(8)) dut_a (
    .cpu_clock_i(clk), .cpu_reset_i(rst), .valid_i(valid), .is_store_i(is_store),
    .addr_i(addr), .mem_ctrl_i(ctrl), .ld_raw_i(ld_raw), .ld_data_o(ld_data_a),
    .st_data_i(st_in), .st_data_o(st_data_a), .st_sel_o(st_sel_a),
    .misalign_o(mis_a), .err_sticky_o(sticky_a), .err_count_o(count_a)
  );

  load_store_format #(.ERR_CNT_W(2)) dut_b (
    .cpu_clock_i(clk), .cpu_reset_i(rst), .valid_i(valid), .is_store_i(is_store),
    .addr_i(addr), .mem_ctrl_i(ctrl), .ld_raw_i(ld_raw), .ld_data_o(ld_data_b),
    .st_data_i(st_in), .st_data_o(st_data_b), .st_sel_o(st_sel_b),
    .misalign_o(mis_b), .err_sticky_o(sticky_b), .err_count_o(count_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] raw);
    int unsigned b, h;
    b = (raw >> (8 * a)) % 256;
    h = (raw >> (16 * a[1])) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return raw;
    endcase
  endfunction

  function automatic logic [31:0] model_st_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3 % 4)
      0:       return (d % 256) * 32'h0101_0101;
      1:       return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] model_st_sel(input logic [2:0] f3, input logic [1:0] a);
    case (f3 % 4)
      0:       return 4'(1 << a);
      1:       return (a >= 2) ? 4'd12 : 4'd3;
      2:       return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  function automatic bit model_mis(input bit v, input bit st, input logic [2:0] f3,
                                   input logic [1:0] a);
    int bytes;
    if (!v) return 1'b0;
    if (st && f3 % 4 == 3) return 1'b1;
    if (st) bytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    else    bytes = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
    return (a % bytes) != 0;
  endfunction

  // Apply one cycle of inputs, check combinational outputs, clock, check registered outputs.
  task automatic step(input string tag, input bit r, input bit v, input bit st,
                      input logic [2:0] f3, input logic [1:0] a,
                      input logic [31:0] raw, input logic [31:0] sd);
    bit m;
    @(negedge clk);
    rst = r; valid = v; is_store = st; ctrl = f3; addr = a; ld_raw = raw; st_in = sd;
    #1;
    m = model_mis(v, st, f3, a);
    check({tag, ".ld"},  ld_data_a, model_load(f3, a, raw));
    check({tag, ".std"}, st_data_a, model_st_data(f3, sd));
    check({tag, ".sel"}, 32'(st_sel_a), 32'(model_st_sel(f3, a)));
    check({tag, ".mis"}, 32'(mis_a), 32'(m));
    check({tag, ".ld_b"}, ld_data_b, model_load(f3, a, raw));
    if (r) begin
      ref_cnt = 0; ref_sticky = 1'b0;
    end else if (m) begin
      ref_cnt++; ref_sticky = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, ".sticky"},   32'(sticky_a), 32'(ref_sticky));
    check({tag, ".cnt"},      32'(count_a), (ref_cnt > 255) ? 32'd255 : 32'(ref_cnt));
    check({tag, ".cnt_sat"},  32'(count_b), (ref_cnt > 3) ? 32'd3 : 32'(ref_cnt));
    check({tag, ".sticky_b"}, 32'(sticky_b), 32'(ref_sticky));
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; is_store = 1'b0; addr = 2'd0; ctrl = 3'd0;
    ld_raw = 32'h0; st_in = 32'h0;

    step("reset", 1, 1, 0, 3'b010, 2'd1, 32'h0, 32'h0);

    step("lb3",  0, 0, 0, 3'b000, 2'd3, 32'h80FF_7F01, 32'h0);
    check("lb3.plan", ld_data_a, 32'hFFFF_FF80);
    step("lbu3", 0, 0, 0, 3'b100, 2'd3, 32'h80FF_7F01, 32'h0);
    check("lbu3.plan", ld_data_a, 32'h0000_0080);
    step("lb0",  0, 0, 0, 3'b000, 2'd0, 32'h80FF_7F01, 32'h0);
    check("lb0.plan", ld_data_a, 32'h0000_0001);
    step("lh2",  0, 0, 0, 3'b001, 2'd2, 32'h80FF_7F01, 32'h0);
    check("lh2.plan", ld_data_a, 32'hFFFF_80FF);
    step("lhu0", 0, 0, 0, 3'b101, 2'd0, 32'h80FF_7F01, 32'h0);
    check("lhu0.plan", ld_data_a, 32'h0000_7F01);
    step("lw",   0, 0, 0, 3'b010, 2'd0, 32'h80FF_7F01, 32'h0);
    check("lw.plan", ld_data_a, 32'h80FF_7F01);

    step("sb2", 0, 0, 1, 3'b000, 2'd2, 32'h0, 32'h1234_5678);
    check("sb2.plan_d", st_data_a, 32'h7878_7878);
    check("sb2.plan_s", 32'(st_sel_a), 32'h4);
    step("sh2", 0, 0, 1, 3'b001, 2'd2, 32'h0, 32'h1234_5678);
    check("sh2.plan_d", st_data_a, 32'h5678_5678);
    check("sh2.plan_s", 32'(st_sel_a), 32'hC);
    step("sw0", 0, 0, 1, 3'b010, 2'd0, 32'h0, 32'h1234_5678);
    check("sw0.plan_s", 32'(st_sel_a), 32'hF);

    step("lw_mis", 0, 1, 0, 3'b010, 2'd1, 32'h0, 32'h0);
    check("lw_mis.plan_cnt", 32'(count_a), 32'd1);
    step("lw_idle", 0, 0, 0, 3'b010, 2'd1, 32'h0, 32'h0);
    check("lw_idle.plan_cnt", 32'(count_a), 32'd1);
    step("st11", 0, 1, 1, 3'b111, 2'd0, 32'h0, 32'hCAFE_F00D);
    check("st11.plan_sel", 32'(st_sel_a), 32'h0);

    step("rst_mis", 1, 1, 0, 3'b010, 2'd3, 32'h0, 32'h0);
    check("rst_mis.plan_cnt", 32'(count_a), 32'd0);
    for (int i = 0; i < 5; i++)
      step($sformatf("sat%0d", i), 0, 1, 0, 3'b001, 2'd1, 32'h0, 32'h0);
    check("sat.plan_b", 32'(count_b), 32'd3);
    check("sat.plan_a", 32'(count_a), 32'd5);

    for (int i = 0; i < 300; i++)
      step($sformatf("rnd%0d", i), ($urandom_range(0, 31) == 0), 1'($urandom),
           1'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
